// File: rtl/soc_evt_tx_pkg.sv
// Shared types and helpers for the SoC-to-cluster event transmitter.
// The drop-mode build (SOC_EVT_TX_DROP_EN) uses the same package.
package soc_evt_tx_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        WAIT_ACK = 2'd2
    } state_e;

    // Occupancy counter must represent 0..DEPTH inclusive.
    function automatic int unsigned level_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int unsigned LEVEL_W = level_w(4);

    // Johnson step on the low bw bits of a 64-bit container: shift up, feed back ~MSB.
    function automatic logic [63:0] johnson_next(input logic [63:0] tok, input int unsigned bw);
        logic [63:0] nxt;
        logic [63:0] mask;
        logic [5:0]  msb;
        msb    = 6'(bw - 1);
        nxt    = {tok[62:0], ~tok[msb]};
        mask   = (bw >= 64) ? '1 : ((64'd1 << bw) - 64'd1);
        return nxt & mask;
    endfunction

endpackage

// File: rtl/soc_evt_tx_fifo.sv
// Small synchronous FIFO; refuses pushes while full and pops while empty.
module soc_evt_tx_fifo
    import soc_evt_tx_pkg::*;
#(
    parameter int unsigned EVNT_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              push_i,
    input  logic [EVNT_WIDTH-1:0]             data_i,
    input  logic                              pop_i,
    output logic [EVNT_WIDTH-1:0]             head_o,
    output logic                              full_o,
    output logic                              empty_o,
    output logic [level_w(FIFO_DEPTH)-1:0]    level_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = level_w(FIFO_DEPTH);

    logic [EVNT_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [EVNT_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_q, wr_d, rd_q, rd_d;
    logic [LVL_W-1:0]      cnt_q, cnt_d;
    logic                  do_push, do_pop;

    assign full_o  = (cnt_q == LVL_W'(FIFO_DEPTH));
    assign empty_o = (cnt_q == '0);
    assign level_o = cnt_q;
    assign head_o  = mem_q[rd_q];

    // A full FIFO refuses a push even if the same cycle pops.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q + LVL_W'(do_push) - LVL_W'(do_pop);
        if (do_push) begin
            mem_d[wr_q] = data_i;
            wr_d        = wr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/soc_cluster_evt_tx.sv
// SoC-side event transmitter: FIFO, rp synchroniser and Johnson-token handshake FSM.
// Define SOC_EVT_TX_DROP_EN to drop (and count) events instead of applying backpressure.
module soc_cluster_evt_tx
    import soc_evt_tx_pkg::*;
#(
    parameter int unsigned EVNT_WIDTH   = 8,
    parameter int unsigned BUFFER_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           evt_valid_i,
    input  logic [EVNT_WIDTH-1:0]          evt_data_i,
    output logic                           evt_ready_o,
    output logic [BUFFER_WIDTH-1:0]        cluster_events_wt_o,
    input  logic [BUFFER_WIDTH-1:0]        cluster_events_rp_i,
    output logic [EVNT_WIDTH-1:0]          cluster_events_da_o,
    output logic [level_w(FIFO_DEPTH)-1:0] fifo_level_o,
`ifdef SOC_EVT_TX_DROP_EN
    input  logic                           drop_clr_i,
    output logic [7:0]                     drop_cnt_o,
`endif
    output logic                           busy_o
);

    localparam int unsigned LVL_W = level_w(FIFO_DEPTH);

    state_e                                   state_q, state_d;
    logic [BUFFER_WIDTH-1:0]                  wt_q, wt_d;
    logic [EVNT_WIDTH-1:0]                    da_q, da_d;
    logic [SYNC_STAGES-1:0][BUFFER_WIDTH-1:0] sync_q, sync_d;
    logic [BUFFER_WIDTH-1:0]                  rp_sync;
    logic [63:0]                              wt_adv;
    logic                                     unused_wt_adv;
    logic                                     push, pop, full, empty;
    logic [EVNT_WIDTH-1:0]                    head;
    logic [LVL_W-1:0]                         level;

    soc_evt_tx_fifo #(
        .EVNT_WIDTH (EVNT_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (evt_data_i),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

`ifdef SOC_EVT_TX_DROP_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic       drop;

    assign evt_ready_o = 1'b1;
    assign push        = evt_valid_i;
    assign drop        = evt_valid_i && full;
    assign drop_cnt_o  = drop_cnt_q;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_clr_i) begin
            drop_cnt_d = '0;
        end else if (drop && drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) drop_cnt_q <= '0;
        else         drop_cnt_q <= drop_cnt_d;
    end
`else
    assign evt_ready_o = !full;
    assign push        = evt_valid_i && !full;
`endif

    // Only the last synchroniser stage may feed logic; rp_i is asynchronous.
    always_comb begin
        sync_d[0] = cluster_events_rp_i;
        for (int i = 1; i < int'(SYNC_STAGES); i++) sync_d[i] = sync_q[i-1];
    end
    assign rp_sync = sync_q[SYNC_STAGES-1];

    assign wt_adv        = johnson_next(64'(wt_q), BUFFER_WIDTH);
    assign unused_wt_adv = ^wt_adv;

    // da is loaded one cycle before wt advances, so the receiver never sees it change under a live token.
    always_comb begin
        state_d = state_q;
        wt_d    = wt_q;
        da_d    = da_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty && wt_q == rp_sync) begin
                    pop     = 1'b1;
                    da_d    = head;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                wt_d    = wt_adv[BUFFER_WIDTH-1:0];
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (rp_sync == wt_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            wt_q    <= '0;
            da_q    <= '0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            wt_q    <= wt_d;
            da_q    <= da_d;
            sync_q  <= sync_d;
        end
    end

    assign cluster_events_wt_o = wt_q;
    assign cluster_events_da_o = da_q;
    assign fifo_level_o        = level;
    assign busy_o              = (level != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_soc_cluster_evt_tx.sv
// Directed + randomized bench for soc_cluster_evt_tx with a queue-based receiver model.
module tb_soc_cluster_evt_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       vld = 1'b0;
    logic [7:0] dat = 8'h00;
    logic [7:0] rp = 8'h00;
    logic       rdy;
    logic [7:0] wt, da;
    logic [2:0] lvl;
    logic       busy;
`ifdef SOC_EVT_TX_DROP_EN
    logic       drop_clr = 1'b0;
    logic [7:0] drop_cnt;
`endif

    soc_cluster_evt_tx #(
        .EVNT_WIDTH   (8),
        .BUFFER_WIDTH (8),
        .FIFO_DEPTH   (4),
        .SYNC_STAGES  (2)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .evt_valid_i         (vld),
        .evt_data_i          (dat),
        .evt_ready_o         (rdy),
        .cluster_events_wt_o (wt),
        .cluster_events_rp_i (rp),
        .cluster_events_da_o (da),
        .fifo_level_o        (lvl),
`ifdef SOC_EVT_TX_DROP_EN
        .drop_clr_i          (drop_clr),
        .drop_cnt_o          (drop_cnt),
`endif
        .busy_o              (busy)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] mq[$];
    int         n_dlv = 0;
    bit         ack_en = 0;
    bit         rec_en = 1;
    bit         seen = 0;
    int         pend = 0;
    int         rmax = 0;
    logic [7:0] da_lat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Token after n handshakes: n ones filling from the LSB, then zeros filling from the LSB.
    function automatic logic [7:0] jn(input int n);
        int m;
        m = n % 16;
        if (m <= 8) return 8'((1 << m) - 1);
        return 8'((255 << (m - 8)) & 255);
    endfunction

    // One clock: record an accepted event, then act as the cluster receiver at the falling edge.
    task automatic tick();
        logic [7:0] e;
        if (rec_en && vld && rdy) mq.push_back(dat);
        @(negedge clk);
        if (ack_en && wt !== rp) begin
            if (!seen) begin
                seen   = 1;
                da_lat = da;
                pend   = int'($urandom_range(rmax, 0));
                chk("wt_step", 32'(wt), 32'(jn(n_dlv + 1)));
                e = (mq.size() > 0) ? mq.pop_front() : 8'hxx;
                chk("evt_data", 32'(da), 32'(e));
            end else begin
                chk("da_stable", 32'(da), 32'(da_lat));
            end
            if (pend == 0) begin
                rp    = wt;
                n_dlv = n_dlv + 1;
                seen  = 0;
            end else begin
                pend = pend - 1;
            end
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 600 && (busy || mq.size() > 0 || wt !== rp); i++) tick();
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_queue"}, 32'(mq.size()), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_wt"}, 32'(wt), 32'd0);
        chk({tag, "_da"}, 32'(da), 32'd0);
        chk({tag, "_ready"}, 32'(rdy), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_level"}, 32'(lvl), 32'd0);
`ifdef SOC_EVT_TX_DROP_EN
        chk({tag, "_dropcnt"}, 32'(drop_cnt), 32'd0);
`endif
        mq.delete();
        rp     = 8'h00;
        vld    = 1'b0;
        n_dlv  = 0;
        seen   = 0;
        ack_en = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n0;
        int lvl_exp [6] = '{0, 1, 1, 2, 3, 4};

        @(negedge clk);
        do_reset("rst");

        // Single event: da at cycle 2, token at cycle 3, idle three cycles after the ack.
        vld = 1'b1; dat = 8'hA5;
        tick();
        vld = 1'b0;
        chk("single_lvl_c0", 32'(lvl), 32'd1);
        chk("single_wt_c0", 32'(wt), 32'd0);
        tick();
        chk("single_da_c1", 32'(da), 32'hA5);
        chk("single_wt_c1", 32'(wt), 32'd0);
        tick();
        chk("single_wt_c2", 32'(wt), 32'h01);
        chk("single_busy_c2", 32'(busy), 32'd1);
        ack_en = 1; rmax = 0;
        tick();
        chk("single_rp", 32'(rp), 32'h01);
        tick();
        chk("single_busy_s1", 32'(busy), 32'd1);
        tick();
        chk("single_busy_s2", 32'(busy), 32'd1);
        tick();
        chk("single_idle", 32'(busy), 32'd0);
        chk("single_dlv", 32'(n_dlv), 32'd1);

`ifndef SOC_EVT_TX_DROP_EN
        // Backpressure: one event in flight, four queued, the sixth refused.
        ack_en = 0;
        n0 = n_dlv;
        for (int i = 0; i < 6; i++) begin
            vld = 1'b1; dat = 8'($urandom);
            chk("bp_level", 32'(lvl), 32'(lvl_exp[i]));
            chk("bp_ready", 32'(rdy), (i == 5) ? 32'd0 : 32'd1);
            tick();
        end
        chk("bp_full_level", 32'(lvl), 32'd4);
        chk("bp_full_ready", 32'(rdy), 32'd0);
        vld = 1'b0;
        ack_en = 1; rmax = 3;
        drain("bp_drain");
        chk("bp_count", 32'(n_dlv - n0), 32'd5);
`endif

        // Wrap: 17 handshakes from a fresh token walk the whole Johnson cycle.
        do_reset("wrap_rst");
        ack_en = 1; rmax = 0;
        for (int i = 0; i < 17; i++) begin
            vld = 1'b1; dat = 8'($urandom);
            for (int k = 0; k < 60 && !rdy; k++) tick();
            tick();
            vld = 1'b0;
            for (int k = 0; k < 60 && busy; k++) tick();
        end
        drain("wrap_drain");
        chk("wrap_count", 32'(n_dlv), 32'd17);
        chk("wrap_wt", 32'(wt), 32'h01);

`ifndef SOC_EVT_TX_DROP_EN
        // Random traffic with random ack latency.
        n0 = n_dlv;
        rmax = 4;
        for (int i = 0; i < 200; i++) begin
            vld = ($urandom_range(2, 0) != 0);
            dat = 8'($urandom);
            tick();
        end
        vld = 1'b0;
        n0 = n0 + mq.size();
        drain("rand_drain");
`endif

        // Mid-operation reset with three events queued behind an outstanding one.
        ack_en = 0;
        for (int i = 0; i < 4; i++) begin
            vld = 1'b1; dat = 8'($urandom);
            tick();
        end
        vld = 1'b0;
        tick(); tick();
        chk("mid_level", 32'(lvl), 32'd3);
        chk("mid_busy", 32'(busy), 32'd1);
        do_reset("mid_rst");
        ack_en = 1;
        for (int i = 0; i < 10; i++) tick();
        chk("mid_post_wt", 32'(wt), 32'd0);
        chk("mid_post_da", 32'(da), 32'd0);
        chk("mid_post_busy", 32'(busy), 32'd0);
        chk("mid_post_dlv", 32'(n_dlv), 32'd0);

`ifdef SOC_EVT_TX_DROP_EN
        // Drop mode: five accepted, the rest counted until saturation.
        ack_en = 0; rec_en = 0;
        vld = 1'b1;
        for (int i = 0; i < 15; i++) begin
            dat = 8'($urandom);
            tick();
        end
        chk("drop_cnt_10", 32'(drop_cnt), 32'd10);
        for (int i = 0; i < 300; i++) begin
            dat = 8'($urandom);
            tick();
            if (i % 50 == 0) chk("drop_ready", 32'(rdy), 32'd1);
        end
        chk("drop_sat", 32'(drop_cnt), 32'hFF);
        drop_clr = 1'b1;
        tick();
        drop_clr = 1'b0;
        vld = 1'b0;
        chk("drop_clr", 32'(drop_cnt), 32'd0);
        rec_en = 1;
        do_reset("drop_rst");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/soc_cluster_evt_tx.md
Name: soc_cluster_evt_tx

Overview:
SoC-side transmitter that feeds the SoC-to-cluster event bus (cluster_events_wt/rp/da) exported by the SoC domain toward the cluster. It buffers events from the SoC event generator in a small FIFO. Events are sent one at a time over a token handshake: Johnson-coded write token out, write data out, and a Johnson-coded read pointer returned from the cluster clock domain.

Parameters:
EVNT_WIDTH, 8, width of one event word.
BUFFER_WIDTH, 8, Johnson token width (2*BUFFER_WIDTH token states); must be >=2.
FIFO_DEPTH, 4, input FIFO entries; power of two, >=2.
SYNC_STAGES, 2, flops in the read-pointer synchroniser; >=2.

Ports:
clk_i  in  1  SoC clock.
rst_ni  in  1  reset; one clock; asynchronous, active-low.
evt_valid_i  in  1  event request from SoC event generator.
evt_data_i  in  EVNT_WIDTH  event word.
evt_ready_o  out  1  event accepted when valid && ready.
cluster_events_wt_o  out  BUFFER_WIDTH  Johnson write token to cluster.
cluster_events_rp_i  in  BUFFER_WIDTH  Johnson read pointer from cluster (asynchronous).
cluster_events_da_o  out  EVNT_WIDTH  event data; stable whenever wt != synced rp.
fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
busy_o  out  1  high when FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset: wt_o=0, da_o=0, evt_ready_o=1, fifo_level_o=0, busy_o=0, synchroniser flops=0, FSM=IDLE.
- Johnson advance: wt_next = {wt[BW-2:0], ~wt[BW-1]}. Exactly one bit changes per step. Wraps after 2*BW steps (8-bit: 0x00->0x01->...->0xFF->0xFE->...->0x80->0x00).
- rp_sync: rp_i passed through SYNC_STAGES flops. Only rp_sync is used in logic.
- FIFO:
  - push when evt_valid_i && evt_ready_o; evt_ready_o = !full.
  - Push while full is refused, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle when not full/empty: level unchanged.
  - Write/read pointers wrap modulo FIFO_DEPTH.
- FSM:
  - IDLE: if FIFO non-empty && wt==rp_sync: pop, register da_o<=head, go SETUP. Otherwise stay.
  - SETUP: wt advances one step (da_o already stable one cycle). Go WAIT_ACK.
  - WAIT_ACK: hold wt and da_o. When rp_sync==wt, go IDLE.
- At most one event outstanding. da_o never changes while wt != rp_sync.
- Latency, push into empty idle block at cycle 0:
  - da_o valid in cycle 2.
  - new wt visible in cycle 3.
  - Earliest next pop is the cycle after rp_sync matches wt. Minimum per-event period is 3 + SYNC_STAGES + receiver latency.
- rp_sync != wt and != wt's predecessor (protocol violation): remain in WAIT_ACK; no recovery other than reset.
- Reset mid-operation: all state cleared asynchronously; FIFO content lost. The cluster receiver shares the global reset, so its rp returns to 0 as well.
- busy_o = (level!=0) || (state!=IDLE).

Optional Feature:
Macro SOC_EVT_TX_DROP_EN.
- Defined:
  - evt_ready_o tied 1.
  - An event presented while FIFO is full is discarded.
  - Extra output drop_cnt_o (8 bit, reset 0) increments per discarded event and saturates at 0xFF.
  - Extra input drop_clr_i: clears the counter. Clear has priority over a simultaneous increment.
- Undefined: backpressure via evt_ready_o=!full; no drop_cnt_o/drop_clr_i ports.

Decomposition:
- Package soc_evt_tx_pkg:
  - FSM state enum (IDLE, SETUP, WAIT_ACK).
  - function johnson_next(token).
  - localparam LEVEL_W derivation.
- Sub-module soc_evt_tx_fifo: synchronous FIFO, parameters EVNT_WIDTH and FIFO_DEPTH. Outputs full, empty, level, head data.
- Synchroniser and FSM live in the top.

Test Plan:
- Reset: assert rst_ni=0 mid-cycle -> immediately wt_o=0x00, da_o=0x00, evt_ready_o=1, busy_o=0, fifo_level_o=0.
- Single event: push 0xA5 at cycle 0, receiver echoes rp=wt after 4 cycles -> da_o=0xA5 at cycle 2, wt_o=0x01 at cycle 3, FSM back to IDLE after rp_sync=0x01.
- Backpressure: push 6 events with rp held at 0 -> first event in flight, 4 held in FIFO, evt_ready_o=0 for events 6 onward, fifo_level_o=4; release rp -> events delivered in order.
- Wrap: send 17 events with prompt acks -> wt sequence 0x01,0x03,...,0xFF,0xFE,...,0x80,0x00,0x01; data order preserved.
- Mid-operation reset: reset during WAIT_ACK with 3 queued -> all outputs at reset values, no stale event emitted after release.
- SOC_EVT_TX_DROP_EN: fill FIFO, present 300 extra events -> drop_cnt_o saturates at 0xFF, evt_ready_o stays 1; drop_clr_i pulse -> drop_cnt_o=0.
